mc_control_fsm: RTL and testbench

//  Multicycle MIPS32 main controller: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
//  and drives datapath selects, write strobes and the 2-bit aluop consumed by the ALU decoder.

---
 rtl/mc_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS32 main controller: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB.
// Memory states (FETCH, MEMRD, MEMWR) hold and repeat their outputs until mem_ready.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic pcwrite_c;
  logic branch_c;
  logic irwrite_c;
  logic memwrite_c;
  logic regwrite_c;
  logic illegal_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;

    case (state_q)
      S_FETCH: begin
        // PC and IR only advance on the cycle the instruction read completes
        alusrcb   = 2'b01;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_c = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are gated by reset_n so an asynchronous reset kills any write in the same cycle
  assign pcen       = reset_n & (pcwrite_c | (branch_c & zero));
  assign irwrite    = reset_n & irwrite_c;
  assign memwrite   = reset_n & memwrite_c;
  assign regwrite   = reset_n & regwrite_c;
  assign illegal_op = reset_n & illegal_c;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       illegal_op;
  logic [14:0] got;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010, XX = 6'b111111;

  // Instruction steps used by the reference model
  localparam int F = 0, D = 1, A = 2, R = 3, MW = 4, WR = 5, RX = 6, RW = 7;
  localparam int BX = 8, IX = 9, IW = 10, JX = 11;

  mc_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign got = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, aluop, illegal_op};

  function automatic logic [14:0] mk(input logic pc, irw, mw, rw, io, m2r, rd, sa,
                                     input logic [1:0] sb, ps, ao, input logic il);
    return {pc, irw, mw, rw, io, m2r, rd, sa, sb, ps, ao, il};
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    return (o == RT) || (o == LW) || (o == SW) || (o == BQ) || (o == AI) || (o == JJ);
  endfunction

  function automatic logic [14:0] exp_vec(input int st, input logic [5:0] o,
                                          input logic z, input logic mr);
    case (st)
      F:       return mk(mr, mr, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      D:       return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, !is_legal(o));
      A, IX:   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      R:       return mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      MW:      return mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      WR:      return mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      RX:      return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0);
      RW:      return mk(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      BX:      return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      IW:      return mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      JX:      return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
      default: return 15'h0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] o, input logic mr, input logic z);
    @(negedge clk);
    op = o;
    mem_ready = mr;
    zero = z;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        mr;
    logic        zr;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [5:0] o, input logic mr, input logic z,
                     input logic [14:0] e);
    vec_t v;
    v.name = nm; v.op = o; v.mr = mr; v.zr = z; v.exp = e;
    tbl.push_back(v);
  endtask

  // Reference model: an instruction is a list of steps; memory steps repeat while stalled
  int cur;
  int plan[$];
  logic [5:0] mop;

  task automatic model_advance(input logic [5:0] o, input logic mr);
    if (cur == F) begin
      if (mr) cur = D;
    end else if (cur == D) begin
      mop = o;
      plan.delete();
      if (o == LW) plan = '{A, R, MW};
      else if (o == SW) plan = '{A, WR};
      else if (o == RT) plan = '{RX, RW};
      else if (o == BQ) plan = '{BX};
      else if (o == AI) plan = '{IX, IW};
      else if (o == JJ) plan = '{JX};
      cur = (plan.size() > 0) ? plan.pop_front() : F;
    end else if ((cur == R || cur == WR) && !mr) begin
      cur = cur;
    end else begin
      cur = (plan.size() > 0) ? plan.pop_front() : F;
    end
  endtask

  logic [14:0] v_rst;
  logic [5:0]  legal_ops [6];

  initial begin
    v_rst = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    legal_ops = '{RT, LW, SW, BQ, AI, JJ};

    // Reset: strobes forced low even with mem_ready high
    reset_n = 1'b0; op = XX; zero = 1'b0; mem_ready = 1'b1;
    #3;
    check("reset_outputs", v_rst);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // LW, no stalls: 5 cycles
    add("lw_fetch",  XX, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("lw_decode", LW, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    add("lw_memadr", LW, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
    add("lw_memrd",  RT, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add("lw_memwb",  JJ, 1, 0, mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    // RTYPE
    add("rt_fetch",  SW, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("rt_decode", RT, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    add("rt_exec",   LW, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0));
    add("rt_wb",     XX, 1, 0, mk(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
    // BEQ taken and not taken
    add("beq1_fetch",  XX, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("beq1_decode", BQ, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    add("beq1_exec",   XX, 1, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0));
    add("beq0_fetch",  XX, 1, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("beq0_decode", BQ, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    add("beq0_exec",   XX, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0));
    // Illegal opcode, then J proves the FSM returned to FETCH
    add("ill_fetch",  RT, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("ill_decode", XX, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1));
    add("j_fetch",    XX, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("j_decode",   JJ, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    add("j_exec",     LW, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0));
    // ADDI
    add("addi_fetch",  XX, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("addi_decode", AI, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    add("addi_exec",   RT, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
    add("addi_wb",     XX, 1, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    // SW with fetch stall and three MEMWR stall cycles
    add("sw_fetch_stall0", XX, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("sw_fetch_stall1", LW, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("sw_fetch",        XX, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    add("sw_decode",       SW, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    add("sw_memadr",       SW, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
    for (int i = 0; i < 3; i++)
      add("sw_memwr_stall", XX, 0, 0, mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add("sw_memwr_done",   XX, 1, 0, mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    add("sw_back_fetch",   XX, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));

    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].mr, tbl[i].zr);
      check(tbl[i].name, tbl[i].exp);
    end

    // Reset asserted mid-MEMWR drops memwrite asynchronously
    step(XX, 1, 0);
    step(SW, 1, 0);
    step(SW, 1, 0);
    step(XX, 0, 0);
    check("rst_pre_memwr", mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    #2 reset_n = 1'b0;
    #1 check("rst_async_drop", v_rst);
    step(XX, 1, 0);
    check("rst_held_gated", v_rst);
    reset_n = 1'b1;
    #1 check("rst_release_fetch", mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    step(AI, 1, 0);
    check("rst_then_decode", mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));

    // Randomized run against the reference model
    @(negedge clk);
    reset_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cur = F;
    plan.delete();
    mop = XX;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mem_ready = ($urandom_range(0, 9) < 7);
      zero = 1'($urandom_range(0, 1));
      if (cur == D) begin
        int r;
        r = $urandom_range(0, 7);
        op = (r < 6) ? legal_ops[r] : 6'($urandom);
      end else if (cur == A) begin
        op = mop;
      end else begin
        op = 6'($urandom);
      end
      #1;
      check("random", exp_vec(cur, op, zero, mem_ready));
      model_advance(op, mem_ready);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
